// File: rtl/riscv_pkg.sv
// Shared RV32I constants and MEM-stage types.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // Instruction fields held for the whole memory transaction.
  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        regwrite;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_cap_t;

  // Legal size code for the access kind, and natural alignment for that size.
  function automatic logic access_legal(input logic is_load, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic f3_ok;
    logic size_ok;
    f3_ok = is_load ? (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) : (f3 < 3'b011);
    case (f3[1:0])
      2'b01:   size_ok = ~a[0];
      2'b10:   size_ok = (a == 2'b00);
      default: size_ok = 1'b1;
    endcase
    return f3_ok & size_ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a raw load word and extends it.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Shift the addressed lane down, then sign/zero-extend by access type.
  always_comb begin
    byte_sh = rdata >> {addr_lo, 3'b000};
    half_sh = rdata >> {addr_lo[1], 4'b0000};
    case (funct3)
      F3_B:    data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_H:    data = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_W:    data = rdata;
      F3_BU:   data = {24'h0, byte_sh[7:0]};
      F3_HU:   data = {16'h0, half_sh[15:0]};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: issues one load/store at a time, stalls upstream while it
// is outstanding, and forwards ALU results untouched.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       store_data_in,
  input  logic [4:0]        rd_in,
  input  logic              regwrite_in,
  input  logic [6:0]        op_in,
  input  logic [2:0]        funct3_in,
  output logic              stall_o,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata,
  output logic              out_valid,
  output logic [31:0]       dm_out,
  output logic [31:0]       alu_out,
  output logic [4:0]        rd_out,
  output logic              regwrite_out,
  output logic [6:0]        op_out,
  output logic              misalign_o
);

  mem_state_t  state, state_nxt;
  mem_cap_t    cap;
  logic [31:0] dm_q;
  logic        is_load_in, is_store_in, is_mem_in, legal_in, take, drop;
  logic [3:0]  wstrb_in;
  logic [31:0] wdata_in;
  logic [31:0] ld_data;

  assign is_load_in  = (op_in == OP_LOAD);
  assign is_store_in = (op_in == OP_STORE);
  assign is_mem_in   = in_valid & (is_load_in | is_store_in);
  assign legal_in    = access_legal(is_load_in, funct3_in, alu_in[1:0]);
  assign take        = (state == IDLE) & is_mem_in & legal_in;
  assign drop        = (state == IDLE) & is_mem_in & ~legal_in;

  // Replicate store data across byte lanes and build the matching strobe.
  always_comb begin
    wstrb_in = 4'b1111;
    wdata_in = store_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        wstrb_in = 4'b0001 << alu_in[1:0];
        wdata_in = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        wstrb_in = 4'b0011 << alu_in[1:0];
        wdata_in = {2{store_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .rdata   (mem_rsp_rdata),
    .addr_lo (cap.alu[1:0]),
    .funct3  (cap.funct3),
    .data    (ld_data)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: responses only count while waiting for one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take)          state_nxt = REQ;
      REQ:  if (mem_req_ready) state_nxt = cap.we ? DONE : WAIT;
      WAIT: if (mem_rsp_valid) state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Capture the instruction on acceptance and the aligned word on response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap  <= '0;
      dm_q <= '0;
    end else begin
      if (take) begin
        cap.alu      <= alu_in;
        cap.rd       <= rd_in;
        cap.regwrite <= regwrite_in;
        cap.op       <= op_in;
        cap.funct3   <= funct3_in;
        cap.we       <= is_store_in;
        cap.wdata    <= is_store_in ? wdata_in : 32'h0;
        cap.wstrb    <= is_store_in ? wstrb_in : 4'h0;
        dm_q         <= '0;
      end
      if (state == WAIT && mem_rsp_valid) dm_q <= ld_data;
    end
  end

  // Outputs: pass-through in IDLE, captured fields in DONE, silent otherwise.
  always_comb begin
    out_valid     = 1'b0;
    alu_out       = alu_in;
    rd_out        = rd_in;
    regwrite_out  = regwrite_in;
    op_out        = op_in;
    dm_out        = 32'h0;
    stall_o       = 1'b0;
    misalign_o    = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        out_valid = in_valid & ~take;
        stall_o   = take;
        if (drop) begin
          regwrite_out = 1'b0;
          misalign_o   = 1'b1;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        stall_o       = 1'b1;
      end
      WAIT: stall_o = 1'b1;
      DONE: begin
        out_valid    = 1'b1;
        alu_out      = cap.alu;
        rd_out       = cap.rd;
        regwrite_out = cap.regwrite;
        op_out       = cap.op;
        dm_out       = dm_q;
      end
      default: ;
    endcase
  end

  assign mem_req_we    = cap.we;
  assign mem_req_addr  = {cap.alu[ADDR_W-1:2], 2'b00};
  assign mem_req_wdata = cap.wdata;
  assign mem_req_wstrb = cap.wstrb;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a behavioural memory.
module tb_mem_access_stage;
  import riscv_pkg::*;

  logic        clk, reset;
  logic        in_valid, regwrite_in;
  logic [31:0] alu_in, store_data_in;
  logic [4:0]  rd_in;
  logic [6:0]  op_in;
  logic [2:0]  funct3_in;
  logic        stall_o, mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        out_valid, regwrite_out, misalign_o;
  logic [31:0] dm_out, alu_out;
  logic [4:0]  rd_out;
  logic [6:0]  op_out;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_in(alu_in),
    .store_data_in(store_data_in), .rd_in(rd_in), .regwrite_in(regwrite_in),
    .op_in(op_in), .funct3_in(funct3_in), .stall_o(stall_o),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .dm_out(dm_out), .alu_out(alu_out), .rd_out(rd_out),
    .regwrite_out(regwrite_out), .op_out(op_out), .misalign_o(misalign_o)
  );

  typedef struct {
    logic [31:0] alu; logic [4:0] rd; logic rw; logic [6:0] op;
    logic [31:0] dm; logic mis;
  } exp_t;
  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int total = 0, bad = 0;
  bit rand_mode = 0;
  int fix_rdy = 0, fix_rsp = 0;
  bit force_en = 0;
  logic [31:0] force_val = 32'h0;
  int late_rsp_at = -1;
  int cyc = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    return force_en ? force_val : ((wa * 32'h9E3779B1) ^ 32'h5A5AC3C3);
  endfunction

  function automatic bit ref_legal(input bit ld, input logic [2:0] f3, input logic [1:0] a);
    int sz;
    if (ld) begin
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 0;
    end else if (f3 > 3'd2) return 0;
    sz = 1 << f3[1:0];
    return (int'(a) % sz) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return b - ((b & 32'h80) << 1);
      3'd1:    return h - ((h & 32'h8000) << 1);
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Drive one instruction at a negedge, queue its expectations, hold it while stalled.
  task automatic issue(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                       input logic rw, input bit use_dm, input logic [31:0] dm_x,
                       output int stalls, output int rvcnt);
    exp_t e; req_t r; bit ld, mem, ok, done; int n;
    in_valid = v; op_in = op; funct3_in = f3; alu_in = a;
    store_data_in = sd; rd_in = rd; regwrite_in = rw;
    ld  = (op == OP_LOAD);
    mem = v && (ld || op == OP_STORE);
    ok  = mem && ref_legal(ld, f3, a[1:0]);
    e.alu = a; e.rd = rd; e.rw = rw; e.op = op; e.dm = 32'h0; e.mis = 0;
    if (mem && !ok) begin e.rw = 0; e.mis = 1; end
    if (ok) begin
      r.we = !ld; r.addr = a & ~32'h3; r.wdata = 32'h0; r.wstrb = 4'h0;
      if (ld) e.dm = use_dm ? dm_x : ref_load(mem_word(r.addr), a[1:0], f3);
      else begin
        n = 1 << f3[1:0];
        r.wstrb = 4'(((1 << n) - 1) << a[1:0]);
        if (n == 1)      r.wdata = (sd & 32'hFF) * 32'h01010101;
        else if (n == 2) r.wdata = (sd & 32'hFFFF) * 32'h00010001;
        else             r.wdata = sd;
      end
      req_q.push_back(r);
    end
    if (v) exp_q.push_back(e);
    stalls = 0; rvcnt = 0; done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      #1;
      if (mem_req_valid) rvcnt++;
      if (!stall_o) done = 1;
      else begin stalls++; @(negedge clk); end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL issue_timeout: stall_o still 1 after 100 cycles, want 0");
    end
    @(negedge clk);
  endtask

  // Output monitor: every presented result must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (!reset) begin
        if (out_valid) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL out_unexpected: out_valid=1 alu=%h, want no output", alu_out);
          end else begin
            e = exp_q.pop_front();
            if (alu_out !== e.alu || rd_out !== e.rd || regwrite_out !== e.rw ||
                op_out !== e.op || misalign_o !== e.mis || (!e.mis && dm_out !== e.dm)) begin
              bad++;
              $display("FAIL out_fields: got alu=%h rd=%0d rw=%b op=%h dm=%h mis=%b want alu=%h rd=%0d rw=%b op=%h dm=%h mis=%b",
                       alu_out, rd_out, regwrite_out, op_out, dm_out, misalign_o,
                       e.alu, e.rd, e.rw, e.op, e.dm, e.mis);
            end
          end
        end
        total++;
        if ((out_valid && stall_o) || (misalign_o && !out_valid)) begin
          bad++;
          $display("FAIL out_protocol: out_valid=%b stall_o=%b misalign_o=%b", out_valid, stall_o, misalign_o);
        end
      end
    end
  end

  // Memory model: ready latency, response latency, request checking.
  initial begin
    int rsp_cnt, vcnt, cur_lat;
    logic [31:0] rsp_addr;
    req_t r;
    rsp_cnt = -1; vcnt = 0; cur_lat = 0; rsp_addr = 32'h0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 0; mem_rsp_rdata = $urandom;
      if (rsp_cnt == 0) begin
        mem_rsp_valid = 1; mem_rsp_rdata = mem_word(rsp_addr); rsp_cnt = -1;
      end else if (rsp_cnt > 0) rsp_cnt--;
      else if (cyc == late_rsp_at || (rand_mode && $urandom_range(0, 7) == 0))
        mem_rsp_valid = 1;
      if (mem_req_valid) begin
        if (vcnt == 0) cur_lat = rand_mode ? int'($urandom_range(0, 3)) : fix_rdy;
        mem_req_ready = (vcnt >= cur_lat);
        vcnt++;
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1));
        vcnt = 0;
      end
      #3;
      if (reset) begin
        rsp_cnt = -1; vcnt = 0;
      end else if (mem_req_valid) begin
        total++;
        if (req_q.size() == 0) begin
          bad++;
          $display("FAIL req_unexpected: mem_req_valid=1 addr=%h, want no request", mem_req_addr);
        end else begin
          r = req_q[0];
          if (mem_req_we !== r.we || mem_req_addr !== r.addr ||
              (r.we && (mem_req_wdata !== r.wdata || mem_req_wstrb !== r.wstrb))) begin
            bad++;
            $display("FAIL req_fields: got we=%b addr=%h wdata=%h wstrb=%b want we=%b addr=%h wdata=%h wstrb=%b",
                     mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
                     r.we, r.addr, r.wdata, r.wstrb);
          end
          if (mem_req_ready) begin
            void'(req_q.pop_front());
            vcnt = 0;
            if (!r.we) begin
              rsp_cnt  = rand_mode ? int'($urandom_range(0, 2)) : fix_rsp;
              rsp_addr = mem_req_addr;
            end
          end
        end
      end
    end
  end

  initial begin
    int s, rv;
    logic [6:0] op;
    logic [31:0] a;
    reset = 1; in_valid = 0; alu_in = 0; store_data_in = 0; rd_in = 0;
    regwrite_in = 0; op_in = 0; funct3_in = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_req_wdata", mem_req_wdata, 32'h0);
    chk("rst_dm_out", dm_out, 32'h0);
    chk("rst_misalign", {31'h0, misalign_o}, 32'h0);
    @(negedge clk); reset = 0;
    @(negedge clk);

    // ALU pass-through
    issue(1, 7'b0110011, 3'd0, 32'h1234, 32'h0, 5'd5, 1, 0, 0, s, rv);
    chk("add_stall_cycles", s, 0);
    // LB / LBU at 0x103, zero-wait memory
    force_en = 1; force_val = 32'h80FF0000;
    issue(1, OP_LOAD, F3_B, 32'h103, 32'h0, 5'd7, 1, 1, 32'hFFFFFF80, s, rv);
    chk("lb_stall_cycles", s, 3);
    issue(1, OP_LOAD, F3_BU, 32'h103, 32'h0, 5'd8, 1, 1, 32'h00000080, s, rv);
    chk("lbu_stall_cycles", s, 3);
    force_en = 0;
    // SH at 0x22 with ready held low for 2 cycles
    fix_rdy = 2;
    issue(1, OP_STORE, F3_H, 32'h22, 32'hABCD1234, 5'd0, 0, 0, 0, s, rv);
    chk("sh_req_valid_cycles", rv, 3);
    chk("sh_stall_cycles", s, 4);
    fix_rdy = 0;
    // misaligned LW is dropped
    issue(1, OP_LOAD, F3_W, 32'h2, 32'h0, 5'd9, 1, 0, 0, s, rv);
    chk("lw_mis_stall", s, 0);
    chk("lw_mis_req_cycles", rv, 0);
    // back-to-back LW, SW
    issue(1, OP_LOAD, F3_W, 32'h40, 32'h0, 5'd10, 1, 0, 0, s, rv);
    chk("b2b_lw_stall", s, 3);
    issue(1, OP_STORE, F3_W, 32'h44, 32'hCAFEF00D, 5'd0, 0, 0, 0, s, rv);
    chk("b2b_sw_stall", s, 2);

    // reset while waiting for a load response, then a late response
    fix_rsp = 50;
    req_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0, wstrb: 4'h0});
    in_valid = 1; op_in = OP_LOAD; funct3_in = F3_W; alu_in = 32'h80; rd_in = 5'd3; regwrite_in = 1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("wait_stall", {31'h0, stall_o}, 32'h1);
    chk("wait_req_valid", {31'h0, mem_req_valid}, 32'h0);
    reset = 1; in_valid = 0; op_in = 0; funct3_in = 0; alu_in = 0; rd_in = 0; regwrite_in = 0;
    exp_q.delete(); req_q.delete();
    #1;
    chk("midrst_stall", {31'h0, stall_o}, 32'h0);
    chk("midrst_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("midrst_dm_out", dm_out, 32'h0);
    @(negedge clk); reset = 0; late_rsp_at = cyc + 1;
    fix_rsp = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("post_rst_stall", {31'h0, stall_o}, 32'h0);
      chk("post_rst_out_valid", {31'h0, out_valid}, 32'h0);
    end
    @(negedge clk);
    issue(1, 7'b0110011, 3'd0, 32'h5555, 32'h0, 5'd11, 1, 0, 0, s, rv);
    chk("post_rst_add_stall", s, 0);

    // randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    op = OP_LOAD;
        2:       op = OP_STORE;
        default: op = $urandom_range(0, 1) ? 7'b0110011 : 7'b0010011;
      endcase
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      issue(1'($urandom_range(0, 5) != 0), op, 3'($urandom_range(0, 7)), a, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, 0, s, rv);
    end
    rand_mode = 0;
    in_valid = 0;
    repeat (5) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("req_queue_drained", req_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
